isp_debayer_ctrl: RTL

Timing and configuration sequencer for the demosaic stage. It tracks pixel and line position from the raw sync signals and supplies the per-pixel Bayer phase. It applies Bayer-order and bypass settings atomically at frame boundaries. It regenerates href, vsync and de delayed by a programmable pipeline latency, using an edge-timestamp FIFO instead of a per-cycle shift register, and flags frame-geometry errors.

---
 rtl/isp_debayer_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/isp_debayer_ctrl.sv
// isp_debayer_ctrl: pixel/line position tracking, per-pixel Bayer phase,
// frame-atomic configuration and latency-matched sync regeneration for the
// demosaic stage. Sync outputs are rebuilt from a small FIFO of edge
// timestamps, so storage scales with edge count rather than latency.
module isp_debayer_ctrl #(
   parameter int unsigned WIDTH      = 1280,
   parameter int unsigned HEIGHT     = 960,
   parameter int unsigned BAYER      = 0,
   parameter int unsigned LATENCY    = 2566,
   parameter int unsigned TS_W       = 13,
   parameter int unsigned EDGE_DEPTH = 8
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        in_href,
   input  logic        in_vsync,
   input  logic        in_de,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [1:0]  cfg_bayer,
   input  logic        cfg_bypass,
   input  logic        err_clr,
   output logic [1:0]  active_bayer,
   output logic        active_bypass,
   output logic [1:0]  pix_fmt,
   output logic [11:0] pix_x,
   output logic [11:0] line_y,
   output logic        frame_start,
   output logic        out_href,
   output logic        out_vsync,
   output logic        out_de,
   output logic        err_line_len,
   output logic        err_line_cnt,
   output logic        err_ovf
);

   localparam int unsigned     AW        = $clog2(EDGE_DEPTH);
   localparam logic [TS_W-1:0] LAT_TS    = TS_W'(LATENCY);
   localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(EDGE_DEPTH);
   localparam logic [11:0]     WIDTH_C   = 12'(WIDTH);
   localparam logic [11:0]     HEIGHT_C  = 12'(HEIGHT);
   localparam logic [1:0]      BAYER_C   = 2'(BAYER);

   // {href, vsync, de} as seen on the previous cycle
   logic [2:0]      r_sync_d;
   logic [11:0]     r_pix_x;
   logic [11:0]     r_line_y;
   logic            r_first;
   logic            r_err_len;
   logic            r_err_cnt;
   logic            r_err_ovf;
   logic            r_pending;
   logic [1:0]      r_shadow_bayer;
   logic            r_shadow_bypass;
   logic [1:0]      r_act_bayer;
   logic            r_act_bypass;
   logic [TS_W-1:0] r_ts;
   logic [AW:0]     r_wptr;
   logic [AW:0]     r_rptr;
   logic [2:0]      r_out_st;
   logic [TS_W-1:0] r_mem_ts [EDGE_DEPTH];
   logic [2:0]      r_mem_st [EDGE_DEPTH];

   logic [2:0]      w_in_st;
   logic            w_fs;
   logic            w_fall;
   logic            w_chg;
   logic [AW:0]     w_cnt;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_push_ok;
   logic            w_drop;
   logic            w_accept;

   // Edge detection, FIFO status and handshake qualifiers
   always_comb begin
      w_in_st   = {in_href, in_vsync, in_de};
      w_fs      = in_vsync & ~r_sync_d[1];
      w_fall    = r_sync_d[2] & ~in_href;
      w_chg     = (w_in_st != r_sync_d);
      w_cnt     = r_wptr - r_rptr;
      w_empty   = (r_wptr == r_rptr);
      w_full    = (w_cnt == DEPTH_CNT);
      w_pop     = ~w_empty && (r_ts == r_mem_ts[r_rptr[AW-1:0]] + LAT_TS);
      w_push_ok = w_chg && (~w_full || w_pop);
      w_drop    = w_chg && w_full && ~w_pop;
      w_accept  = cfg_valid & ~r_pending;
   end

   // Previous-cycle sync sample and pixel/line position counters
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_sync_d <= '0;
         r_pix_x  <= '0;
         r_line_y <= '0;
      end else begin
         r_sync_d <= w_in_st;
         if (w_fs) begin
            r_pix_x  <= '0;
            r_line_y <= '0;
         end else if (w_fall) begin
            r_pix_x  <= '0;
            r_line_y <= r_line_y + 12'd1;
         end else if (in_href && (r_pix_x != '1)) begin
            r_pix_x  <= r_pix_x + 12'd1;
         end
      end
   end

   // Sticky geometry/overflow errors; a fresh error outranks err_clr
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_first   <= 1'b1;
         r_err_len <= 1'b0;
         r_err_cnt <= 1'b0;
         r_err_ovf <= 1'b0;
      end else begin
         if (w_fs) r_first <= 1'b0;
         if (w_fall && (r_pix_x != WIDTH_C)) r_err_len <= 1'b1;
         else if (err_clr)                   r_err_len <= 1'b0;
         if (w_fs && ~r_first && (r_line_y != HEIGHT_C)) r_err_cnt <= 1'b1;
         else if (err_clr)                               r_err_cnt <= 1'b0;
         if (w_drop)       r_err_ovf <= 1'b1;
         else if (err_clr) r_err_ovf <= 1'b0;
      end
   end

   // Config shadow and frame-boundary commit. Accept needs pending low and
   // commit needs it high, so both never act in the same cycle.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_pending       <= 1'b0;
         r_shadow_bayer  <= '0;
         r_shadow_bypass <= 1'b0;
         r_act_bayer     <= BAYER_C;
         r_act_bypass    <= 1'b0;
      end else begin
         if (w_fs && r_pending) begin
            r_act_bayer  <= r_shadow_bayer;
            r_act_bypass <= r_shadow_bypass;
            r_pending    <= 1'b0;
         end
         if (w_accept) begin
            r_shadow_bayer  <= cfg_bayer;
            r_shadow_bypass <= cfg_bypass;
            r_pending       <= 1'b1;
         end
      end
   end

   // Timestamp counter, FIFO pointers and delayed sync state
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_ts     <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_out_st <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop) begin
            r_rptr   <= r_rptr + 1'b1;
            r_out_st <= r_mem_st[r_rptr[AW-1:0]];
         end
      end
   end

   // Edge FIFO storage; contents are don't-care while the FIFO is empty
   always_ff @(posedge pclk) begin
      if (w_push_ok) begin
         r_mem_ts[r_wptr[AW-1:0]] <= r_ts;
         r_mem_st[r_wptr[AW-1:0]] <= w_in_st;
      end
   end

   assign cfg_ready     = ~r_pending;
   assign active_bayer  = r_act_bayer;
   assign active_bypass = r_act_bypass;
   assign pix_fmt       = r_act_bayer ^ {r_line_y[0], r_pix_x[0]};
   assign pix_x         = r_pix_x;
   assign line_y        = r_line_y;
   assign frame_start   = w_fs;
   assign out_href      = r_out_st[2];
   assign out_vsync     = r_out_st[1];
   assign out_de        = r_out_st[0];
   assign err_line_len  = r_err_len;
   assign err_line_cnt  = r_err_cnt;
   assign err_ovf       = r_err_ovf;

endmodule
